hdlc_rx_ctrl: RTL and testbench
===============================

# hdlc_rx_ctrl

Receive-side frame controller for the HDLC core. It sits between the Rx flag/abort detectors and byte assembler on one side and the Rx frame buffer and status register on the other. It sequences each frame (hunt, sync, receive, done), generates buffer write strobes and addresses, and enforces the maximum frame length. It also signals abort, overflow and FCS error, and holds the buffer until the host releases it.

## Interface
- MAX_BYTES, 128: frame buffer depth in bytes; power of two, 4..256.
- ADDR_W, $clog2(MAX_BYTES): buffer address width.
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- RxEN  in  1  receiver enable from the control register.
- Rx_FlagDetect  in  1  1-cycle strobe; flag pattern 01111110 recognised.
- Rx_AbortDetect  in  1  1-cycle strobe; abort pattern (7 or more ones) recognised.
- Rx_NewByte  in  1  1-cycle strobe; Rx_Byte holds a de-stuffed byte.
- Rx_Byte  in  8  assembled byte.
- Rx_FCSerr  in  1  FCS checker mismatch; valid in the cycle Rx_FlagDetect closes a frame.
- Rx_ReadDone  in  1  1-cycle host pulse; buffer consumed or frame dropped.
- Rx_ValidFrame  out  1  frame in progress.
- Rx_WrBuff  out  1  buffer write strobe.
- Rx_WrAddr  out  ADDR_W  buffer write address.
- Rx_WrData  out  8  buffer write data.
- Rx_Ready  out  1  complete frame available in the buffer.
- Rx_FrameSize  out  ADDR_W+1  payload bytes of the held frame.
- Rx_AbortSignal  out  1  1-cycle pulse; frame aborted.
- Rx_Overflow  out  1  sticky; frame exceeded MAX_BYTES.
- Rx_FrameError  out  1  sticky; FCS error on the held frame.

## Operation
- FSM states: IDLE, SYNC, FRAME, DONE. Reset state is IDLE.
- All outputs are registered. On reset, every output and the byte counter (ADDR_W+1 bits) is 0.
- IDLE to SYNC: Rx_FlagDetect while RxEN=1.
- SYNC:
  - Further flags keep the FSM in SYNC.
  - Rx_NewByte moves to FRAME, writes the byte at address 0, sets count=1, and clears Overflow and FrameError.
  - Rx_AbortDetect returns to IDLE with no AbortSignal.
- FRAME:
  - Rx_ValidFrame=1.
  - Each Rx_NewByte with count<MAX_BYTES writes at address count, then increments count.
  - Rx_NewByte with count=MAX_BYTES sets Rx_Overflow, performs no write, and holds count.
- FRAME, Rx_AbortDetect: AbortSignal pulse, go to IDLE. Buffer contents are discarded and Rx_Ready stays 0.
- FRAME, Rx_FlagDetect (closing flag):
  - If count < MINLEN: runt frame, silently discarded; go to SYNC, because the closing flag also opens the next frame.
  - Otherwise: go to DONE with Rx_Ready=1, FrameSize = count − FCSLEN (or MAX_BYTES − FCSLEN on overflow), and FrameError = Rx_FCSerr.
- DONE:
  - All Rx inputs are ignored and no writes occur.
  - Rx_ReadDone clears Rx_Ready and returns to IDLE, which requires a fresh opening flag.
- RxEN=0 in SYNC or FRAME: go to IDLE silently, with no AbortSignal. In DONE it has no effect.
- Simultaneous events:
  - AbortDetect beats FlagDetect, and FlagDetect beats NewByte; the losing strobe is dropped.
  - Rx_ReadDone outside DONE is ignored.

## Timing
- Strobe at edge N → outputs updated after edge N+1, i.e. 1-cycle latency.
- Rx_WrBuff is high for exactly 1 cycle per accepted byte. Rx_WrAddr and Rx_WrData are valid in the same cycle.
- Rx_AbortSignal is high in the cycle after Rx_AbortDetect whenever Rx_ValidFrame=1 in that cycle.
- Rx_ValidFrame rises together with the first Rx_WrBuff. It falls with Rx_Ready rising, or with the AbortSignal pulse.
- Rx_Overflow and Rx_FrameError persist through DONE and clear only at the next frame's first byte.
- Reset mid-frame: all state returns to IDLE asynchronously; no pulses are emitted.

## Configuration
- HDLC_RX_FCS_EN defined:
  - FCSLEN=2, MINLEN=4.
  - The last two bytes are FCS, are stored, and are excluded from FrameSize.
  - Rx_FCSerr is sampled at the closing flag.
- Undefined:
  - FCSLEN=0, MINLEN=1.
  - FrameSize = stored byte count.
  - Rx_FCSerr is ignored and Rx_FrameError is tied to 0.

## Test plan
- Flag, bytes 0x11 0x22 0x33 0x44 0x55 0x66, flag (FCS_EN):
  - 6 writes at addresses 0..5.
  - Rx_Ready=1, FrameSize=4, FrameError=0.
  - Rx_ReadDone → Ready=0, state IDLE.
- Flag, 3 bytes, Rx_AbortDetect:
  - Rx_AbortSignal pulse 1 cycle after the abort.
  - Ready stays 0; next flag+bytes are received normally.
- Flag, 130 bytes, flag (MAX_BYTES=128):
  - 128 writes; Overflow=1 from the 129th byte.
  - Ready=1, FrameSize=126; Overflow clears at the next frame's first byte.
- Flag, 2 bytes, flag, 5 bytes, flag (FCS_EN):
  - First frame dropped as a runt.
  - Second frame starts at address 0, FrameSize=3.
- Frame ending with Rx_FCSerr=1 at the closing flag → Ready=1, FrameError=1. Bytes arriving before ReadDone produce no Rx_WrBuff.
- Rst low mid-frame, and RxEN=0 mid-frame → all outputs 0, no AbortSignal.
- FlagDetect and NewByte in the same cycle → byte dropped.

Source files
------------

// File: rtl/hdlc_rx_if.sv
// rtl/hdlc_rx_if.sv - Rx frame controller signal bundle (detector/host side vs. controller side)
interface hdlc_rx_if #(
    parameter int ADDR_W = 7
);
    logic              RxEN;
    logic              Rx_FlagDetect;
    logic              Rx_AbortDetect;
    logic              Rx_NewByte;
    logic [7:0]        Rx_Byte;
    logic              Rx_FCSerr;
    logic              Rx_ReadDone;
    logic              Rx_ValidFrame;
    logic              Rx_WrBuff;
    logic [ADDR_W-1:0] Rx_WrAddr;
    logic [7:0]        Rx_WrData;
    logic              Rx_Ready;
    logic [ADDR_W:0]   Rx_FrameSize;
    logic              Rx_AbortSignal;
    logic              Rx_Overflow;
    logic              Rx_FrameError;

    modport master (
        output RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Byte, Rx_FCSerr, Rx_ReadDone,
        input  Rx_ValidFrame, Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_Ready, Rx_FrameSize,
               Rx_AbortSignal, Rx_Overflow, Rx_FrameError
    );

    modport slave (
        input  RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Byte, Rx_FCSerr, Rx_ReadDone,
        output Rx_ValidFrame, Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_Ready, Rx_FrameSize,
               Rx_AbortSignal, Rx_Overflow, Rx_FrameError
    );
endinterface

// File: rtl/hdlc_rx_ctrl.sv
// rtl/hdlc_rx_ctrl.sv - HDLC Rx frame sequencer; HDLC_RX_FCS_EN enables 2-byte FCS handling
module hdlc_rx_ctrl #(
    parameter int MAX_BYTES = 128,
    parameter int ADDR_W    = $clog2(MAX_BYTES)
) (
    input  logic   Clk,
    input  logic   Rst,
    hdlc_rx_if.slave rx
);
`ifdef HDLC_RX_FCS_EN
    localparam int FCSLEN = 2;
    localparam int MINLEN = 4;
`else
    localparam int FCSLEN = 0;
    localparam int MINLEN = 1;
    logic fcs_unused;
    assign fcs_unused = rx.Rx_FCSerr;
`endif
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_BYTES);
    localparam logic [ADDR_W:0] MIN_CNT = (ADDR_W+1)'(MINLEN);
    localparam logic [ADDR_W:0] FCS_CNT = (ADDR_W+1)'(FCSLEN);

    typedef enum logic [1:0] {IDLE, SYNC, FRAME, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              valid_frame_q, valid_frame_d;
    logic              wr_buff_q, wr_buff_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              ready_q, ready_d;
    logic [ADDR_W:0]   frame_size_q, frame_size_d;
    logic              abort_q, abort_d;
    logic              overflow_q, overflow_d;
    logic              frame_error_q, frame_error_d;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            valid_frame_q <= 1'b0;
            wr_buff_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            ready_q       <= 1'b0;
            frame_size_q  <= '0;
            abort_q       <= 1'b0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            valid_frame_q <= valid_frame_d;
            wr_buff_q     <= wr_buff_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            ready_q       <= ready_d;
            frame_size_q  <= frame_size_d;
            abort_q       <= abort_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Priority inside a frame: RxEN drop, then abort, then flag, then byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (rx.RxEN && rx.Rx_FlagDetect) state_d = SYNC;
            SYNC: begin
                if (!rx.RxEN || rx.Rx_AbortDetect) state_d = IDLE;
                else if (rx.Rx_FlagDetect)         state_d = SYNC;
                else if (rx.Rx_NewByte)            state_d = FRAME;
            end
            FRAME: begin
                if (!rx.RxEN || rx.Rx_AbortDetect) state_d = IDLE;
                else if (rx.Rx_FlagDetect)         state_d = (count_q < MIN_CNT) ? SYNC : DONE;
            end
            DONE:  if (rx.Rx_ReadDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d       = count_q;
        valid_frame_d = (state_d == FRAME);
        wr_buff_d     = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        ready_d       = ready_q;
        frame_size_d  = frame_size_q;
        abort_d       = 1'b0;
        overflow_d    = overflow_q;
        frame_error_d = frame_error_q;
        case (state_q)
            SYNC: begin
                if (rx.RxEN && !rx.Rx_AbortDetect && !rx.Rx_FlagDetect && rx.Rx_NewByte) begin
                    wr_buff_d     = 1'b1;
                    wr_addr_d     = '0;
                    wr_data_d     = rx.Rx_Byte;
                    count_d       = (ADDR_W+1)'(1);
                    overflow_d    = 1'b0;
                    frame_error_d = 1'b0;
                end
            end
            FRAME: begin
                if (rx.RxEN) begin
                    if (rx.Rx_AbortDetect) begin
                        abort_d = 1'b1;
                    end else if (rx.Rx_FlagDetect) begin
                        // count saturates at MAX_CNT, so the overflow size falls out of the same subtraction
                        if (count_q >= MIN_CNT) begin
                            ready_d      = 1'b1;
                            frame_size_d = count_q - FCS_CNT;
`ifdef HDLC_RX_FCS_EN
                            frame_error_d = rx.Rx_FCSerr;
`endif
                        end
                    end else if (rx.Rx_NewByte) begin
                        if (count_q < MAX_CNT) begin
                            wr_buff_d = 1'b1;
                            wr_addr_d = count_q[ADDR_W-1:0];
                            wr_data_d = rx.Rx_Byte;
                            count_d   = count_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            DONE: if (rx.Rx_ReadDone) ready_d = 1'b0;
            default: ;
        endcase
    end

    assign rx.Rx_ValidFrame  = valid_frame_q;
    assign rx.Rx_WrBuff      = wr_buff_q;
    assign rx.Rx_WrAddr      = wr_addr_q;
    assign rx.Rx_WrData      = wr_data_q;
    assign rx.Rx_Ready       = ready_q;
    assign rx.Rx_FrameSize   = frame_size_q;
    assign rx.Rx_AbortSignal = abort_q;
    assign rx.Rx_Overflow    = overflow_q;
    assign rx.Rx_FrameError  = frame_error_q;
endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// tb/tb_hdlc_rx_ctrl.sv - directed self-checking bench for hdlc_rx_ctrl
module tb_hdlc_rx_ctrl;
`ifdef HDLC_RX_FCS_EN
    localparam int FCSLEN = 2;
    localparam int MINLEN = 4;
    localparam logic FCS_ON = 1'b1;
`else
    localparam int FCSLEN = 0;
    localparam int MINLEN = 1;
    localparam logic FCS_ON = 1'b0;
`endif
    localparam int MAXB = 128;
    localparam int AW   = 7;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    hdlc_rx_if #(.ADDR_W(AW)) rx ();

    hdlc_rx_ctrl #(.MAX_BYTES(MAXB), .ADDR_W(AW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .rx  (rx)
    );

    always #5 Clk = ~Clk;

    task automatic drive(input logic f, input logic a, input logic nb, input logic [7:0] b,
                         input logic fe, input logic rd);
        @(negedge Clk);
        rx.Rx_FlagDetect  = f;
        rx.Rx_AbortDetect = a;
        rx.Rx_NewByte     = nb;
        rx.Rx_Byte        = b;
        rx.Rx_FCSerr      = fe;
        rx.Rx_ReadDone    = rd;
        @(posedge Clk);
        #1;
        rx.Rx_FlagDetect  = 1'b0;
        rx.Rx_AbortDetect = 1'b0;
        rx.Rx_NewByte     = 1'b0;
        rx.Rx_FCSerr      = 1'b0;
        rx.Rx_ReadDone    = 1'b0;
    endtask

    task automatic flag();       drive(1, 0, 0, 8'h00, 0, 0); endtask
    task automatic byte_in(input logic [7:0] b); drive(0, 0, 1, b, 0, 0); endtask
    task automatic read_done();  drive(0, 0, 0, 8'h00, 0, 1); endtask

    task automatic test_reset();
        rx.RxEN = 1'b1; rx.Rx_FlagDetect = 1'b0; rx.Rx_AbortDetect = 1'b0; rx.Rx_NewByte = 1'b0;
        rx.Rx_Byte = 8'h00; rx.Rx_FCSerr = 1'b0; rx.Rx_ReadDone = 1'b0;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++;
        if ({rx.Rx_ValidFrame, rx.Rx_WrBuff, rx.Rx_WrAddr, rx.Rx_WrData, rx.Rx_Ready, rx.Rx_FrameSize,
             rx.Rx_AbortSignal, rx.Rx_Overflow, rx.Rx_FrameError} !== '0) begin
            n_err++; $display("FAIL reset_outputs: outputs not all zero");
        end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_good_frame();
        logic [7:0] bytes [6];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        flag();
        for (int i = 0; i < 6; i++) begin
            byte_in(bytes[i]);
            n_vec++;
            if ({rx.Rx_WrBuff, rx.Rx_ValidFrame, rx.Rx_WrAddr, rx.Rx_WrData} !== {2'b11, 7'(i), bytes[i]}) begin
                n_err++; $display("FAIL good_write%0d: got wr=%b v=%b a=%0d d=%h want a=%0d d=%h",
                                  i, rx.Rx_WrBuff, rx.Rx_ValidFrame, rx.Rx_WrAddr, rx.Rx_WrData, i, bytes[i]);
            end
        end
        flag();
        n_vec++;
        if ({rx.Rx_Ready, rx.Rx_ValidFrame, rx.Rx_FrameSize, rx.Rx_FrameError} !== {2'b10, 8'(6 - FCSLEN), 1'b0}) begin
            n_err++; $display("FAIL good_close: rdy=%b v=%b size=%0d ferr=%b want size=%0d",
                              rx.Rx_Ready, rx.Rx_ValidFrame, rx.Rx_FrameSize, rx.Rx_FrameError, 6 - FCSLEN);
        end
        read_done();
        n_vec++;
        if (rx.Rx_Ready !== 1'b0) begin n_err++; $display("FAIL good_readdone: rdy=%b want 0", rx.Rx_Ready); end
        byte_in(8'hAA);
        n_vec++;
        if (rx.Rx_WrBuff !== 1'b0) begin n_err++; $display("FAIL idle_byte: wr=%b want 0", rx.Rx_WrBuff); end
    endtask

    task automatic test_abort();
        flag();
        byte_in(8'h01); byte_in(8'h02); byte_in(8'h03);
        drive(0, 1, 0, 8'h00, 0, 0);
        n_vec++;
        if ({rx.Rx_AbortSignal, rx.Rx_ValidFrame, rx.Rx_Ready} !== 3'b100) begin
            n_err++; $display("FAIL abort_pulse: ab=%b v=%b rdy=%b want 1 0 0",
                              rx.Rx_AbortSignal, rx.Rx_ValidFrame, rx.Rx_Ready);
        end
        byte_in(8'h04);
        n_vec++;
        if ({rx.Rx_AbortSignal, rx.Rx_WrBuff} !== 2'b00) begin
            n_err++; $display("FAIL abort_after: ab=%b wr=%b want 0 0", rx.Rx_AbortSignal, rx.Rx_WrBuff);
        end
        flag();
        for (int i = 0; i < 5; i++) byte_in(8'h20 + 8'(i));
        n_vec++;
        if ({rx.Rx_WrAddr, rx.Rx_WrData} !== {7'd4, 8'h24}) begin
            n_err++; $display("FAIL abort_next_write: a=%0d d=%h want 4 24", rx.Rx_WrAddr, rx.Rx_WrData);
        end
        flag();
        n_vec++;
        if ({rx.Rx_Ready, rx.Rx_FrameSize} !== {1'b1, 8'(5 - FCSLEN)}) begin
            n_err++; $display("FAIL abort_next_close: rdy=%b size=%0d want 1 %0d",
                              rx.Rx_Ready, rx.Rx_FrameSize, 5 - FCSLEN);
        end
        read_done();
    endtask

    task automatic test_overflow();
        int nw = 0;
        flag();
        for (int i = 0; i < 130; i++) begin
            byte_in(8'(i));
            if (rx.Rx_WrBuff === 1'b1) nw++;
            if (i == 127) begin
                n_vec++;
                if ({rx.Rx_Overflow, rx.Rx_WrAddr} !== {1'b0, 7'd127}) begin
                    n_err++; $display("FAIL ovf_last_write: ovf=%b a=%0d want 0 127", rx.Rx_Overflow, rx.Rx_WrAddr);
                end
            end
            if (i == 128) begin
                n_vec++;
                if ({rx.Rx_Overflow, rx.Rx_WrBuff} !== 2'b10) begin
                    n_err++; $display("FAIL ovf_set: ovf=%b wr=%b want 1 0", rx.Rx_Overflow, rx.Rx_WrBuff);
                end
            end
        end
        n_vec++;
        if (nw !== 128) begin n_err++; $display("FAIL ovf_writes: got %0d want 128", nw); end
        flag();
        n_vec++;
        if ({rx.Rx_Ready, rx.Rx_FrameSize, rx.Rx_Overflow} !== {1'b1, 8'(MAXB - FCSLEN), 1'b1}) begin
            n_err++; $display("FAIL ovf_close: rdy=%b size=%0d ovf=%b want 1 %0d 1",
                              rx.Rx_Ready, rx.Rx_FrameSize, rx.Rx_Overflow, MAXB - FCSLEN);
        end
        read_done();
        flag();
        n_vec++;
        if (rx.Rx_Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: ovf=%b want 1", rx.Rx_Overflow); end
        byte_in(8'h5A);
        n_vec++;
        if ({rx.Rx_Overflow, rx.Rx_WrAddr} !== {1'b0, 7'd0}) begin
            n_err++; $display("FAIL ovf_clear: ovf=%b a=%0d want 0 0", rx.Rx_Overflow, rx.Rx_WrAddr);
        end
        drive(0, 1, 0, 8'h00, 0, 0);
    endtask

    task automatic test_runt();
        logic exp_rdy;
        exp_rdy = (2 >= MINLEN);
        flag();
        byte_in(8'hA0); byte_in(8'hA1);
        flag();
        n_vec++;
        if (rx.Rx_Ready !== exp_rdy) begin
            n_err++; $display("FAIL runt_close: rdy=%b want %b", rx.Rx_Ready, exp_rdy);
        end
        if (exp_rdy) begin
            read_done();
            flag();
        end
        for (int i = 0; i < 5; i++) begin
            byte_in(8'hB0 + 8'(i));
            if (i == 0) begin
                n_vec++;
                if ({rx.Rx_WrBuff, rx.Rx_WrAddr} !== {1'b1, 7'd0}) begin
                    n_err++; $display("FAIL runt_restart: wr=%b a=%0d want 1 0", rx.Rx_WrBuff, rx.Rx_WrAddr);
                end
            end
        end
        flag();
        n_vec++;
        if ({rx.Rx_Ready, rx.Rx_FrameSize} !== {1'b1, 8'(5 - FCSLEN)}) begin
            n_err++; $display("FAIL runt_second: rdy=%b size=%0d want 1 %0d",
                              rx.Rx_Ready, rx.Rx_FrameSize, 5 - FCSLEN);
        end
        read_done();
    endtask

    task automatic test_fcs_err();
        flag();
        for (int i = 0; i < 4; i++) byte_in(8'hC0 + 8'(i));
        drive(1, 0, 0, 8'h00, 1, 0);
        n_vec++;
        if ({rx.Rx_Ready, rx.Rx_FrameError} !== {1'b1, FCS_ON}) begin
            n_err++; $display("FAIL fcs_close: rdy=%b ferr=%b want 1 %b", rx.Rx_Ready, rx.Rx_FrameError, FCS_ON);
        end
        byte_in(8'hEE);
        n_vec++;
        if (rx.Rx_WrBuff !== 1'b0) begin n_err++; $display("FAIL done_no_write: wr=%b want 0", rx.Rx_WrBuff); end
        drive(0, 1, 0, 8'h00, 0, 0);
        n_vec++;
        if ({rx.Rx_AbortSignal, rx.Rx_Ready} !== 2'b01) begin
            n_err++; $display("FAIL done_abort_ignored: ab=%b rdy=%b want 0 1", rx.Rx_AbortSignal, rx.Rx_Ready);
        end
        read_done();
        flag();
        n_vec++;
        if ({rx.Rx_Ready, rx.Rx_FrameError} !== {1'b0, FCS_ON}) begin
            n_err++; $display("FAIL fcs_sticky: rdy=%b ferr=%b want 0 %b", rx.Rx_Ready, rx.Rx_FrameError, FCS_ON);
        end
        byte_in(8'h01);
        n_vec++;
        if (rx.Rx_FrameError !== 1'b0) begin n_err++; $display("FAIL fcs_clear: ferr=%b want 0", rx.Rx_FrameError); end
        drive(0, 1, 0, 8'h00, 0, 0);
    endtask

    task automatic test_disable_reset();
        flag();
        byte_in(8'h10); byte_in(8'h11);
        @(negedge Clk);
        rx.RxEN = 1'b0;
        rx.Rx_AbortDetect = 1'b1;
        @(posedge Clk);
        #1;
        rx.Rx_AbortDetect = 1'b0;
        n_vec++;
        if ({rx.Rx_ValidFrame, rx.Rx_AbortSignal, rx.Rx_Ready} !== 3'b000) begin
            n_err++; $display("FAIL rxen_off: v=%b ab=%b rdy=%b want 0 0 0",
                              rx.Rx_ValidFrame, rx.Rx_AbortSignal, rx.Rx_Ready);
        end
        rx.RxEN = 1'b1;
        flag();
        byte_in(8'h30); byte_in(8'h31);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        n_vec++;
        if ({rx.Rx_ValidFrame, rx.Rx_WrBuff, rx.Rx_WrAddr, rx.Rx_WrData, rx.Rx_Ready, rx.Rx_FrameSize,
             rx.Rx_AbortSignal, rx.Rx_Overflow, rx.Rx_FrameError} !== '0) begin
            n_err++; $display("FAIL async_reset: outputs not all zero v=%b a=%0d", rx.Rx_ValidFrame, rx.Rx_WrAddr);
        end
        @(negedge Clk);
        Rst = 1'b1;
        byte_in(8'h32);
        n_vec++;
        if (rx.Rx_WrBuff !== 1'b0) begin n_err++; $display("FAIL reset_idle: wr=%b want 0", rx.Rx_WrBuff); end
    endtask

    task automatic test_collision();
        flag();
        drive(1, 0, 1, 8'h77, 0, 0);
        n_vec++;
        if ({rx.Rx_WrBuff, rx.Rx_ValidFrame} !== 2'b00) begin
            n_err++; $display("FAIL flag_beats_byte: wr=%b v=%b want 0 0", rx.Rx_WrBuff, rx.Rx_ValidFrame);
        end
        byte_in(8'h78);
        n_vec++;
        if ({rx.Rx_WrBuff, rx.Rx_WrAddr, rx.Rx_WrData} !== {1'b1, 7'd0, 8'h78}) begin
            n_err++; $display("FAIL collide_next: wr=%b a=%0d d=%h want 1 0 78", rx.Rx_WrBuff, rx.Rx_WrAddr, rx.Rx_WrData);
        end
        byte_in(8'h79); byte_in(8'h7A); byte_in(8'h7B);
        drive(1, 1, 0, 8'h00, 0, 0);
        n_vec++;
        if ({rx.Rx_AbortSignal, rx.Rx_Ready} !== 2'b10) begin
            n_err++; $display("FAIL abort_beats_flag: ab=%b rdy=%b want 1 0", rx.Rx_AbortSignal, rx.Rx_Ready);
        end
        read_done();
        n_vec++;
        if (rx.Rx_Ready !== 1'b0) begin n_err++; $display("FAIL readdone_idle: rdy=%b want 0", rx.Rx_Ready); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_abort();
        test_overflow();
        test_runt();
        test_fcs_err();
        test_disable_reset();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
